// File: rtl/vga_multicam_display_if.sv
// Frame buffer read bus shared by all cameras: packed read addresses out,
// packed synchronous-read data back (data valid one clk after the address).
interface vga_multicam_display_if #(
  parameter int NUM_CAM = 2,
  parameter int NB_ADDR = 15,
  parameter int NB_BUF  = 12
);
  logic [NB_ADDR*NUM_CAM-1:0] frame_addr;
  logic [NB_BUF*NUM_CAM-1:0]  frame_pixel;

  modport master (output frame_addr, input frame_pixel);
  modport slave  (input frame_addr, output frame_pixel);
endinterface

// File: rtl/vga_multicam_display.sv
// N-camera framebuffer-to-VGA display. Tiles the camera images side by side,
// or shows one camera at 2x. Adds a per-camera no-signal watchdog, centroid
// bars under each tile and a tile border. Three-stage pipeline: address
// register, frame buffer read, colour register; sync and region flags are
// delayed to match.
module vga_multicam_display #(
  parameter int NUM_CAM     = 2,
  parameter int IMG_COLS    = 160,
  parameter int IMG_ROWS    = 120,
  parameter int NB_ADDR     = $clog2(IMG_COLS*IMG_ROWS),
  parameter int NB_BUF      = 12,
  parameter int TILE_STRIDE = 256,
  parameter int NB_CENTROID = 8,
  parameter int TIMEOUT_FRM = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           visible_i,
  input  logic                           new_pxl_i,
  input  logic                           hsync_i,
  input  logic                           vsync_i,
  input  logic [9:0]                     col_i,
  input  logic [9:0]                     row_i,
  input  logic                           rgbmode_i,
  input  logic                           zoom_i,
  input  logic [1:0]                     cam_sel_i,
  input  logic [NUM_CAM-1:0]             cam_frame_done_i,
  input  logic [3*NUM_CAM-1:0]           rgbfilter_i,
  input  logic [NB_CENTROID*NUM_CAM-1:0] centroid_i,
  vga_multicam_display_if.master         fb,
  output logic                           vga_hsync_o,
  output logic                           vga_vsync_o,
  output logic [3:0]                     vga_red_o,
  output logic [3:0]                     vga_green_o,
  output logic [3:0]                     vga_blue_o
);

  localparam int SEG_W = IMG_COLS / NB_CENTROID;
  localparam int WD_W  = $clog2(TIMEOUT_FRM + 1);

  // The pipeline runs every clk; the pixel enable is not needed.
  logic unused_new_pxl;
  assign unused_new_pxl = new_pxl_i;

  typedef struct packed {
    logic        vis;
    logic        hs;
    logic        vs;
    logic        hit;   // pixel from a frame buffer
    logic [1:0]  cam;   // which camera supplies the pixel
    logic        ovl;   // centroid or border overlay
    logic [11:0] rgb;   // overlay colour
    logic        chk;   // checkerboard phase
  } stage_t;

  int     c_int;
  int     r_int;
  logic   vs_prev_q;
  logic   vs_fall;
  logic   zoom_q;
  logic [1:0] cam_q;
  logic [NUM_CAM-1:0] nosig;
  stage_t s1_d, p1_q, p2_q;
  logic [11:0] colour_d, colour_q;

  assign c_int   = int'(col_i);
  assign r_int   = int'(row_i);
  assign vs_fall = vs_prev_q & ~vsync_i;

  // Frame-start detection and per-frame mode latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_prev_q <= 1'b1;
      zoom_q    <= 1'b0;
      cam_q     <= 2'd0;
    end else begin
      vs_prev_q <= vsync_i;
      if (vs_fall) begin
        zoom_q <= zoom_i;
        cam_q  <= (int'(cam_sel_i) < NUM_CAM) ? cam_sel_i : 2'd0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAM; gi++) begin : g_cam
      localparam int BASE = gi * TILE_STRIDE;
      logic [NB_ADDR-1:0] addr_q;
      logic [NB_ADDR-1:0] addr_d;
      logic               upd;
      logic [WD_W-1:0]    wd_q;

      // Address for this camera; holds outside its active region.
      always_comb begin
        upd    = 1'b0;
        addr_d = addr_q;
        if (zoom_q) begin
          if (int'(cam_q) == gi && c_int < 2*IMG_COLS && r_int < 2*IMG_ROWS) begin
            upd    = 1'b1;
            addr_d = NB_ADDR'((r_int >> 1) * IMG_COLS + (c_int >> 1));
          end
        end else if (c_int >= BASE && c_int < BASE + IMG_COLS && r_int < IMG_ROWS) begin
          upd    = 1'b1;
          addr_d = NB_ADDR'(r_int * IMG_COLS + (c_int - BASE));
        end
      end

      // Stage 1: registered frame buffer address.
      always_ff @(posedge clk) begin
        if (!rst)     addr_q <= '0;
        else if (upd) addr_q <= addr_d;
      end

      // Watchdog: frames since last frame_done, saturating; frame_done wins.
      always_ff @(posedge clk) begin
        if (!rst)                                  wd_q <= WD_W'(TIMEOUT_FRM);
        else if (cam_frame_done_i[gi])             wd_q <= '0;
        else if (vs_fall && int'(wd_q) < TIMEOUT_FRM) wd_q <= wd_q + 1'b1;
      end

      assign fb.frame_addr[gi*NB_ADDR +: NB_ADDR] = addr_q;
      assign nosig[gi] = (int'(wd_q) == TIMEOUT_FRM);
    end
  endgenerate

  // Region classification for the current col/row.
  always_comb begin
    logic cen;
    logic brd;
    logic [11:0] cen_rgb;
    int seg;
    s1_d     = '0;
    s1_d.vis = visible_i;
    s1_d.hs  = hsync_i;
    s1_d.vs  = vsync_i;
    s1_d.chk = col_i[3] ^ row_i[3];
    cen      = 1'b0;
    brd      = 1'b0;
    cen_rgb  = 12'h000;
    seg      = 0;
    if (zoom_q) begin
      if (c_int < 2*IMG_COLS && r_int < 2*IMG_ROWS) begin
        s1_d.hit = 1'b1;
        s1_d.cam = cam_q;
      end
    end else begin
      for (int k = 0; k < NUM_CAM; k++) begin
        if (c_int >= k*TILE_STRIDE && c_int < k*TILE_STRIDE + IMG_COLS) begin
          if (r_int < IMG_ROWS) begin
            s1_d.hit = 1'b1;
            s1_d.cam = 2'(k);
          end else if (r_int < IMG_ROWS + 8) begin
            seg = (c_int - k*TILE_STRIDE) / SEG_W;
            for (int j = 0; j < NB_CENTROID; j++) begin
              if (seg == j && centroid_i[k*NB_CENTROID + j]) begin
                cen     = 1'b1;
                cen_rgb = {{4{rgbfilter_i[3*k+2]}}, {4{rgbfilter_i[3*k+1]}},
                           {4{rgbfilter_i[3*k]}}};
              end
            end
          end
        end
        if ((c_int == k*TILE_STRIDE + IMG_COLS && r_int <= IMG_ROWS) ||
            (r_int == IMG_ROWS && c_int >= k*TILE_STRIDE &&
             c_int <= k*TILE_STRIDE + IMG_COLS))
          brd = 1'b1;
      end
    end
    s1_d.ovl = cen | brd;
    s1_d.rgb = cen ? cen_rgb : (brd ? 12'h088 : 12'h000);
  end

  // Stages 1 and 2 of the flag delay line, aligned with address and BRAM read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p1_q    <= '0;
      p1_q.hs <= 1'b1;
      p1_q.vs <= 1'b1;
      p2_q    <= '0;
      p2_q.hs <= 1'b1;
      p2_q.vs <= 1'b1;
    end else begin
      p1_q <= s1_d;
      p2_q <= p1_q;
    end
  end

  // Colour selection from buffer data and delayed flags.
  always_comb begin
    logic [NB_BUF-1:0] pix;
    logic              ns;
    pix = '0;
    ns  = 1'b0;
    for (int k = 0; k < NUM_CAM; k++) begin
      if (int'(p2_q.cam) == k) begin
        pix = fb.frame_pixel[k*NB_BUF +: NB_BUF];
        ns  = nosig[k];
      end
    end
    colour_d = 12'h000;
    if (!p2_q.vis)
      colour_d = 12'h000;
    else if (p2_q.hit) begin
      if (ns)
        colour_d = p2_q.chk ? 12'h888 : 12'h000;
      else if (rgbmode_i)
        colour_d = pix[11:0];
      else
        colour_d = {pix[7:4], pix[7:4], pix[7:4]};
    end else if (p2_q.ovl)
      colour_d = p2_q.rgb;
  end

  // Stage 3: registered colour and syncs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      colour_q    <= 12'h000;
      vga_hsync_o <= 1'b1;
      vga_vsync_o <= 1'b1;
    end else begin
      colour_q    <= colour_d;
      vga_hsync_o <= p2_q.hs;
      vga_vsync_o <= p2_q.vs;
    end
  end

  assign vga_red_o   = colour_q[11:8];
  assign vga_green_o = colour_q[7:4];
  assign vga_blue_o  = colour_q[3:0];

endmodule
